// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the MIPS MEM stage.
package mips_mem_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // MEM/WB bundle at the default datapath widths
    typedef struct packed {
        logic                  valid;
        logic                  regfile_write;
        logic                  mem_to_reg;
        logic [DATA_W_DEF-1:0] read_from_ram;
        logic [DATA_W_DEF-1:0] alu_result;
        logic [REG_AW_DEF-1:0] write_reg;
    } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: load enable plus synchronous active-high clear.
module mem_wb_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-RAM req/ack handshake, pipe stall, timeout abort and MEM/WB register.
// state | meaning
// IDLE  | sample EX/MEM; retire non-memory / misaligned ops, launch aligned memory ops
// BUSY  | omem_req held; wait for imem_ack or MEM_TIMEOUT cycles
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ivalid,
    input  logic              iSig_MemRead,
    input  logic              iSig_MemWrite,
    input  logic              iSig_regfile_write,
    input  logic              iSig_MemtoReg,
    input  logic [DATA_W-1:0] ialu_result,
    input  logic [DATA_W-1:0] iwrite_data,
    input  logic [REG_AW-1:0] iwrite_reg,
    output logic              omem_req,
    output logic              omem_we,
    output logic [DATA_W-1:0] omem_addr,
    output logic [DATA_W-1:0] omem_wdata,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              ostall,
    output logic              ovalid,
    output logic              oSig_regfile_write,
    output logic              oSig_MemtoReg,
    output logic [DATA_W-1:0] oread_from_ram,
    output logic [DATA_W-1:0] oalu_result,
    output logic [REG_AW-1:0] owrite_reg,
    output logic              oaddr_err,
    output logic              obus_err
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef struct packed {
        logic              valid;
        logic              regfile_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_from_ram;
        logic [DATA_W-1:0] alu_result;
        logic [REG_AW-1:0] write_reg;
    } wb_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              lat_rw_q, lat_rw_d;
    logic              lat_m2r_q, lat_m2r_d;
    logic [REG_AW-1:0] lat_wreg_q, lat_wreg_d;
    logic              addr_err_q, addr_err_d;
    logic              bus_err_q, bus_err_d;
    logic              memop, mis, cnt_last, stall;
    logic              wb_en;
    wb_t               wb_d, wb_q;

    always_comb begin
        memop      = ivalid & (iSig_MemRead | iSig_MemWrite);
        mis        = memop & (ialu_result[1:0] != 2'b00);
        cnt_last   = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_rw_d   = lat_rw_q;
        lat_m2r_d  = lat_m2r_q;
        lat_wreg_d = lat_wreg_q;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        stall      = 1'b0;
        wb_d       = '0;
        // a bundle that is not refreshed is cleared so ovalid drops to a bubble
        wb_en      = wb_q.valid;
        case (state_q)
            IDLE: begin
                if (memop && !mis) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    req_d      = 1'b1;
                    we_d       = iSig_MemWrite;
                    addr_d     = ialu_result;
                    wdata_d    = iwrite_data;
                    lat_rw_d   = iSig_regfile_write;
                    lat_m2r_d  = iSig_MemtoReg;
                    lat_wreg_d = iwrite_reg;
                    stall      = 1'b1;
                end else if (ivalid) begin
                    wb_en              = 1'b1;
                    wb_d.valid         = 1'b1;
                    wb_d.regfile_write = iSig_regfile_write & ~mis;
                    wb_d.mem_to_reg    = iSig_MemtoReg;
                    wb_d.alu_result    = ialu_result;
                    wb_d.write_reg     = iwrite_reg;
                    addr_err_d         = mis;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (imem_ack || cnt_last) begin
                    state_d            = IDLE;
                    req_d              = 1'b0;
                    stall              = 1'b0;
                    wb_en              = 1'b1;
                    wb_d.valid         = 1'b1;
                    wb_d.mem_to_reg    = lat_m2r_q;
                    wb_d.alu_result    = addr_q;
                    wb_d.write_reg     = lat_wreg_q;
                    wb_d.regfile_write = lat_rw_q & imem_ack;
                    wb_d.read_from_ram = (imem_ack && !we_q) ? imem_rdata : '0;
                    bus_err_d          = ~imem_ack;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_rw_q   <= 1'b0;
            lat_m2r_q  <= 1'b0;
            lat_wreg_q <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_rw_q   <= lat_rw_d;
            lat_m2r_q  <= lat_m2r_d;
            lat_wreg_q <= lat_wreg_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    mem_wb_reg #(.W($bits(wb_t))) u_mem_wb (
        .clk (clk),
        .clr (rstn),
        .en  (wb_en),
        .d   (wb_d),
        .q   (wb_q)
    );

    assign omem_req           = req_q;
    assign omem_we            = we_q;
    assign omem_addr          = addr_q;
    assign omem_wdata         = wdata_q;
    assign ostall             = stall;
    assign ovalid             = wb_q.valid;
    assign oSig_regfile_write = wb_q.regfile_write;
    assign oSig_MemtoReg      = wb_q.mem_to_reg;
    assign oread_from_ram     = wb_q.read_from_ram;
    assign oalu_result        = wb_q.alu_result;
    assign owrite_reg         = wb_q.write_reg;
    assign oaddr_err          = addr_err_q;
    assign obus_err           = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops vs a transaction model.
module tb_mem_access_stage;
    localparam int TO = 15;

    logic        clk = 1'b0, rstn = 1'b1;
    logic        ivalid = 1'b0, rd = 1'b0, wr = 1'b0, rw = 1'b0, m2r = 1'b0;
    logic [31:0] alu = '0, wd = '0, rdata = '0;
    logic [4:0]  wreg = '0;
    logic        ack = 1'b0;
    logic        omem_req, omem_we, ostall, ovalid, o_rw, o_m2r, oaddr_err, obus_err;
    logic [31:0] omem_addr, omem_wdata, o_rd, o_alu;
    logic [4:0]  o_wreg;

    mem_access_stage #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .ivalid(ivalid), .iSig_MemRead(rd), .iSig_MemWrite(wr),
        .iSig_regfile_write(rw), .iSig_MemtoReg(m2r), .ialu_result(alu), .iwrite_data(wd),
        .iwrite_reg(wreg), .omem_req(omem_req), .omem_we(omem_we), .omem_addr(omem_addr),
        .omem_wdata(omem_wdata), .imem_ack(ack), .imem_rdata(rdata), .ostall(ostall),
        .ovalid(ovalid), .oSig_regfile_write(o_rw), .oSig_MemtoReg(o_m2r),
        .oread_from_ram(o_rd), .oalu_result(o_alu), .owrite_reg(o_wreg),
        .oaddr_err(oaddr_err), .obus_err(obus_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // bench-side RAM; unwritten words read back a deterministic pattern
    logic [31:0] ram [logic [31:0]];
    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : (a ^ 32'hA5A5_0000);
    endfunction

    typedef struct {
        bit          v;
        bit          rw;
        bit          m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
        bit          aerr;
        bit          berr;
    } exp_t;
    exp_t pend;

    // Issue one instruction starting just after a rising edge; returns just after the edge
    // that retires it, with its expected WB record in pend.
    task automatic issue(input logic r, input logic w, input logic rwi, input logic mi,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] wr_i,
                         input int ack_k, input string tag);
        bit   memop, mis, acked;
        int   n;
        exp_t e;
        memop = r | w;
        mis   = memop && (a[1:0] != 2'b00);
        ivalid = 1'b1; rd = r; wr = w; rw = rwi; m2r = mi; alu = a; wd = d; wreg = wr_i;
        ack = 1'b0;
        @(negedge clk);
        total++;
        if (pend.v) begin
            if ({ovalid, o_rw, o_m2r, o_rd, o_alu, o_wreg, oaddr_err, obus_err} !==
                {1'b1, pend.rw, pend.m2r, pend.rd, pend.alu, pend.wreg, pend.aerr, pend.berr}) begin
                bad++;
                $display("FAIL %s prev_wb: got v=%b rw=%b m2r=%b rd=%h alu=%h wreg=%0d ae=%b be=%b need rw=%b m2r=%b rd=%h alu=%h wreg=%0d ae=%b be=%b",
                         tag, ovalid, o_rw, o_m2r, o_rd, o_alu, o_wreg, oaddr_err, obus_err,
                         pend.rw, pend.m2r, pend.rd, pend.alu, pend.wreg, pend.aerr, pend.berr);
            end
        end else if ({ovalid, oaddr_err, obus_err} !== 3'b000) begin
            bad++;
            $display("FAIL %s prev_bubble: got v/ae/be=%b%b%b need 000", tag, ovalid, oaddr_err, obus_err);
        end
        total++;
        if (omem_req !== 1'b0) begin
            bad++; $display("FAIL %s req_idle: got %b need 0", tag, omem_req);
        end
        total++;
        if (ostall !== (memop && !mis)) begin
            bad++; $display("FAIL %s stall_accept: got %b need %b", tag, ostall, memop && !mis);
        end
        e = '{default: 0};
        e.v = 1; e.alu = a; e.wreg = wr_i; e.m2r = mi;
        if (!memop) begin
            e.rw = rwi;
        end else if (mis) begin
            e.aerr = 1;
        end else begin
            n = 0;
            acked = 0;
            do begin
                @(posedge clk); #1;
                n++;
                acked = (n == ack_k);
                ack   = acked;
                rdata = acked ? ram_rd(a) : $urandom;
                @(negedge clk);
                total++;
                if ({omem_req, omem_we, omem_addr, omem_wdata, ovalid} !== {1'b1, w, a, d, 1'b0}) begin
                    bad++;
                    $display("FAIL %s busy_bus c%0d: got req=%b we=%b addr=%h wd=%h v=%b need req=1 we=%b addr=%h wd=%h v=0",
                             tag, n, omem_req, omem_we, omem_addr, omem_wdata, ovalid, w, a, d);
                end
                if (acked || n < TO) begin
                    total++;
                    if (ostall !== !acked) begin
                        bad++; $display("FAIL %s busy_stall c%0d: got %b need %b", tag, n, ostall, !acked);
                    end
                end
            end while (!acked && n < TO);
            if (acked) begin
                e.rw = rwi;
                e.rd = w ? 32'h0 : ram_rd(a);
                if (w) ram[a] = d;
            end else begin
                e.berr = 1;
            end
        end
        @(posedge clk); #1;
        ack = 1'b0;
        pend = e;
    endtask

    // Idle cycles with ivalid low and junk on the other inputs; optional spurious acks.
    task automatic idle(input int cycles, input bit spurious, input string tag);
        repeat (cycles) begin
            ivalid = 1'b0; rd = 1'($urandom); wr = 1'($urandom); alu = $urandom;
            ack = spurious ? 1'($urandom) : 1'b0; rdata = $urandom;
            @(negedge clk);
            total++;
            if (pend.v) begin
                if ({ovalid, o_rw, o_m2r, o_rd, o_alu, o_wreg, oaddr_err, obus_err} !==
                    {1'b1, pend.rw, pend.m2r, pend.rd, pend.alu, pend.wreg, pend.aerr, pend.berr}) begin
                    bad++;
                    $display("FAIL %s wb: got v=%b rw=%b m2r=%b rd=%h alu=%h wreg=%0d ae=%b be=%b need rw=%b m2r=%b rd=%h alu=%h wreg=%0d ae=%b be=%b",
                             tag, ovalid, o_rw, o_m2r, o_rd, o_alu, o_wreg, oaddr_err, obus_err,
                             pend.rw, pend.m2r, pend.rd, pend.alu, pend.wreg, pend.aerr, pend.berr);
                end
            end else if ({ovalid, oaddr_err, obus_err} !== 3'b000) begin
                bad++;
                $display("FAIL %s bubble: got v/ae/be=%b%b%b need 000", tag, ovalid, oaddr_err, obus_err);
            end
            total++;
            if ({omem_req, ostall} !== 2'b00) begin
                bad++; $display("FAIL %s idle_req_stall: got %b%b need 00", tag, omem_req, ostall);
            end
            @(posedge clk); #1;
            pend = '{default: 0};
        end
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; ivalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({omem_req, omem_we, omem_addr, omem_wdata, ostall, ovalid, o_rw, o_m2r, o_rd, o_alu, o_wreg, oaddr_err, obus_err} !== '0) begin
            bad++; $display("FAIL reset_outputs: got req=%b v=%b addr=%h alu=%h need all 0", omem_req, ovalid, omem_addr, o_alu);
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        pend = '{default: 0};
    endtask

    task automatic test_alu_op();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 0, "alu_op");
        idle(1, 0, "alu_op");
    endtask

    task automatic test_load();
        ram[32'h40] = 32'hDEAD_BEEF;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd8, 3, "lw_40");
        total++;
        if (pend.rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL lw_40 model_rd: got %h need deadbeef", pend.rd);
        end
        idle(1, 0, "lw_40");
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h1234, 5'd0, 1, "sw_44");
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 5'd9, 2, "lw_44");
        idle(1, 0, "lw_44");
        total++;
        if (ram_rd(32'h44) !== 32'h1234) begin
            bad++; $display("FAIL sw_44 ram: got %h need 00001234", ram_rd(32'h44));
        end
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h5555, 5'd3, 1, "rw_both");
        idle(1, 0, "rw_both");
    endtask

    task automatic test_misaligned();
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0, 5'd7, 1, "lw_42");
        idle(2, 0, "lw_42");
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h103, 32'h77, 5'd2, 1, "sw_103");
        idle(1, 0, "sw_103");
    endtask

    task automatic test_timeout();
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h50, 32'h0, 5'd4, 99, "lw_to");
        idle(4, 1, "lw_to_spurious");
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h54, 32'h0, 5'd6, TO, "lw_ack_last");
        idle(1, 0, "lw_ack_last");
    endtask

    task automatic test_reset_mid();
        ivalid = 1'b1; rd = 1'b1; wr = 1'b0; rw = 1'b1; m2r = 1'b1; alu = 32'h80; wreg = 5'd11;
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (omem_req !== 1'b1) begin
                bad++; $display("FAIL rst_mid pre_req: got %b need 1", omem_req);
            end
            @(posedge clk); #1;
        end
        rstn = 1'b1; ivalid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0; ack = 1'b1; rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        total++;
        if ({omem_req, omem_we, omem_addr, ostall, ovalid, o_rw, o_rd, oaddr_err, obus_err} !== '0) begin
            bad++; $display("FAIL rst_mid outputs: got req=%b addr=%h stall=%b v=%b need all 0", omem_req, omem_addr, ostall, ovalid);
        end
        @(posedge clk); #1;
        ack = 1'b0;
        pend = '{default: 0};
        idle(1, 0, "rst_mid_late_ack");
    endtask

    task automatic test_back_to_back();
        ram[32'h60] = 32'h0BAD_CAFE;
        ram[32'h64] = 32'h1357_9BDF;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h60, 32'h0, 5'd12, 1, "b2b_lw0");
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h64, 32'h0, 5'd13, 2, "b2b_lw1");
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h99, 32'h0, 5'd14, 0, "b2b_alu");
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h60, 32'hFEED, 5'd0, 1, "b2b_sw");
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h60, 32'h0, 5'd15, 1, "b2b_lw2");
        idle(1, 0, "b2b_end");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          kind, ak;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if (kind == 9) a[1:0] = 2'($urandom_range(1, 3));
            ak = $urandom_range(1, 5);
            if ($urandom_range(0, 9) == 0) ak = $urandom_range(TO, TO + 2);
            case (kind)
                0, 1:    issue(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 0, "rnd_alu");
                2, 3, 4: issue(1'b1, 1'b0, 1'($urandom), 1'b1, a, $urandom, 5'($urandom), ak, "rnd_lw");
                5, 6:    issue(1'b0, 1'b1, 1'($urandom), 1'b0, a, $urandom, 5'($urandom), ak, "rnd_sw");
                7:       issue(1'b1, 1'b1, 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom), ak, "rnd_both");
                default: issue(1'($urandom), 1'b1, 1'b1, 1'($urandom), a, $urandom, 5'($urandom), ak, "rnd_mis");
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'($urandom), "rnd_gap");
        end
        idle(1, 0, "rnd_end");
    endtask

    initial begin
        pend = '{default: 0};
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
